// File: rtl/pixel_sink_fb_if.sv
// Drawer pixel-write interface: one pixel per cycle while plot is high, full is backpressure.
interface pixel_sink_fb_if #(
    parameter int CWIDTH = 3
);
    logic              plot;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [CWIDTH-1:0] color;
    logic              full;

    modport master (output plot, output x, output y, output color, input full);
    modport slave  (input plot, input x, input y, input color, output full);
endinterface

// File: rtl/pixel_sink_fb.sv
// Pixel sink: FIFO + 2-stage read-modify-write into a WIDTH x HEIGHT framebuffer, with collision detect.
// Optional power-up clear sweep enabled by PIXEL_SINK_CLEAR_ON_RESET_EN.
module pixel_sink_fb #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CWIDTH = 3,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    pixel_sink_fb_if.slave     pix,
    input  logic               freeze,
    output logic               overflow,
    output logic               busy,
    output logic               collision,
    input  logic               coll_clear,
    input  logic [7:0]         rd_x,
    input  logic [6:0]         rd_y,
    output logic [CWIDTH-1:0]  rd_color
);
    localparam int AW   = 15;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [CWIDTH-1:0] mem [0:NPIX-1];
    logic [AW-1:0]     fifo_addr_mem  [0:DEPTH-1];
    logic [CWIDTH-1:0] fifo_color_mem [0:DEPTH-1];

    logic [CNTW-1:0]   count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [AW-1:0]     s1_addr_q, s1_addr_d;
    logic [CWIDTH-1:0] s1_color_q, s1_color_d;
    logic              s2_valid_q, s2_valid_d;
    logic [AW-1:0]     s2_addr_q, s2_addr_d;
    logic [CWIDTH-1:0] s2_color_q, s2_color_d;
    logic [CWIDTH-1:0] ram_rdata_q, ram_rdata_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [CWIDTH-1:0] fwd_color_q, fwd_color_d;
    logic              collision_q, collision_d;
    logic              overflow_q, overflow_d;
    logic [CWIDTH-1:0] rd_color_q, rd_color_d;

    logic              in_range, rd_in_range, count_full, accept, enq, deq, ovf_set, coll_set;
    logic [AW-1:0]     in_addr, rd_addr;
    logic [CWIDTH-1:0] old_color;

    logic              sweep_wr, sweep_full, hold_in;
    logic [AW-1:0]     sweep_addr;

`ifdef PIXEL_SINK_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {ST_START, ST_CLEAR, ST_RUN} clr_state_t;
    clr_state_t    clr_state_q, clr_state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        clr_state_d = clr_state_q;
        clr_addr_d  = clr_addr_q;
        case (clr_state_q)
            ST_START: begin
                clr_state_d = ST_CLEAR;
                clr_addr_d  = '0;
            end
            ST_CLEAR: begin
                if (clr_addr_q == AW'(NPIX - 1)) clr_state_d = ST_RUN;
                clr_addr_d = clr_addr_q + AW'(1);
            end
            default: clr_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_state_q <= ST_START;
            clr_addr_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_addr_q  <= clr_addr_d;
        end
    end

    // ST_START is the reset state so full/busy read 0 while resetn is low; inputs are still held off.
    assign sweep_wr   = (clr_state_q == ST_CLEAR);
    assign sweep_full = (clr_state_q == ST_CLEAR);
    assign hold_in    = (clr_state_q != ST_RUN);
    assign sweep_addr = clr_addr_q;
`else
    assign sweep_wr   = 1'b0;
    assign sweep_full = 1'b0;
    assign hold_in    = 1'b0;
    assign sweep_addr = '0;
`endif

    assign in_range    = ({24'd0, pix.x} < 32'(WIDTH)) && ({25'd0, pix.y} < 32'(HEIGHT));
    assign in_addr     = AW'(pix.y) * AW'(WIDTH) + AW'(pix.x);
    assign rd_in_range = ({24'd0, rd_x} < 32'(WIDTH)) && ({25'd0, rd_y} < 32'(HEIGHT));
    assign rd_addr     = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

    assign count_full = (count_q == CNTW'(DEPTH));
    assign accept     = pix.plot && in_range && !hold_in;
    assign enq        = accept && !count_full;
    assign ovf_set    = accept && count_full;
    assign deq        = (count_q != '0) && !freeze && !hold_in;

    // The RAM read issued alongside S1 misses the write S2 performs on the same edge.
    assign old_color = fwd_hit_q ? fwd_color_q : ram_rdata_q;
    assign coll_set  = s2_valid_q && (s2_color_q != '0) && (old_color != '0);

    always_comb begin
        count_d     = count_q + CNTW'(enq) - CNTW'(deq);
        wr_ptr_d    = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;

        s1_valid_d  = deq;
        s1_addr_d   = deq ? fifo_addr_mem[rd_ptr_q]  : s1_addr_q;
        s1_color_d  = deq ? fifo_color_mem[rd_ptr_q] : s1_color_q;

        s2_valid_d  = s1_valid_q;
        s2_addr_d   = s1_addr_q;
        s2_color_d  = s1_color_q;
        ram_rdata_d = mem[s1_addr_q];
        fwd_hit_d   = s2_valid_q && (s2_addr_q == s1_addr_q);
        fwd_color_d = s2_color_q;

        collision_d = coll_set || (collision_q && !coll_clear);
        overflow_d  = ovf_set  || (overflow_q  && !coll_clear);
        rd_color_d  = rd_in_range ? mem[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_color_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_color_q  <= '0;
            ram_rdata_q <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_color_q <= '0;
            collision_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_color_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_color_q  <= s1_color_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
            s2_color_q  <= s2_color_d;
            ram_rdata_q <= ram_rdata_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_color_q <= fwd_color_d;
            collision_q <= collision_d;
            overflow_q  <= overflow_d;
            rd_color_q  <= rd_color_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_mem[wr_ptr_q]  <= in_addr;
            fifo_color_mem[wr_ptr_q] <= pix.color;
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            mem[sweep_addr] <= '0;
        end else if (s2_valid_q) begin
            mem[s2_addr_q] <= s2_color_q;
        end
    end

    assign pix.full  = count_full || sweep_full;
    assign busy      = (count_q != '0) || s1_valid_q || s2_valid_q || sweep_full;
    assign collision = collision_q;
    assign overflow  = overflow_q;
    assign rd_color  = rd_color_q;
endmodule

// File: tb/tb_pixel_sink_fb.sv
// Directed + randomized bench for pixel_sink_fb against an in-order framebuffer model.
module tb_pixel_sink_fb;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int CW = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          freeze = 1'b0;
    logic          coll_clear = 1'b0;
    logic [7:0]    rd_x = '0;
    logic [6:0]    rd_y = '0;
    logic          overflow, busy, collision;
    logic [CW-1:0] rd_color;

    pixel_sink_fb_if #(.CWIDTH(CW)) pif ();

    pixel_sink_fb #(.WIDTH(W), .HEIGHT(H), .CWIDTH(CW), .DEPTH(D)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pix        (pif),
        .freeze     (freeze),
        .overflow   (overflow),
        .busy       (busy),
        .collision  (collision),
        .coll_clear (coll_clear),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_color   (rd_color)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ref_mem [W*H];
    bit ref_coll = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c);
        pif.plot  = 1'b1;
        pif.x     = 8'(x);
        pif.y     = 7'(y);
        pif.color = CW'(c);
        tick();
        pif.plot  = 1'b0;
    endtask

    // Order-level model: each accepted in-range plot overwrites its pixel; colour over colour is a hit.
    task automatic model_apply(input int x, input int y, input int c);
        if (x < W && y < H) begin
            if (c != 0 && ref_mem[y*W + x] != 0) ref_coll = 1'b1;
            ref_mem[y*W + x] = c;
        end
    endtask

    task automatic rd_px(input int x, input int y, output int c);
        rd_x = 8'(x);
        rd_y = 7'(y);
        tick();
        c = int'(rd_color);
    endtask

    task automatic chk_px(input string tag, input int x, input int y);
        int c;
        rd_px(x, y, c);
        chk(tag, c, ref_mem[y*W + x]);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic pulse_clear();
        coll_clear = 1'b1;
        tick();
        coll_clear = 1'b0;
        ref_coll   = 1'b0;
    endtask

    initial begin
        int c, x, y, r;
        pif.plot = 1'b0; pif.x = '0; pif.y = '0; pif.color = '0;
        foreach (ref_mem[i]) ref_mem[i] = 0;

        repeat (3) tick();
        chk("rst_full", pif.full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_collision", collision, 0);
        chk("rst_rd_color", rd_color, 0);
        resetn = 1'b1;
        tick(); tick();

`ifdef PIXEL_SINK_CLEAR_ON_RESET_EN
        chk("sweep_full", pif.full, 1);
        wait_idle(20000);
`else
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++) begin
                drive(xx, yy, 0);
                model_apply(xx, yy, 0);
            end
        drive(W-1, H-1, 0);
        model_apply(W-1, H-1, 0);
        wait_idle(50);
`endif
        chk("init_collision", collision, 0);

        // Single plot latency: write lands at N+3, readable at N+4.
        drive(5, 3, 1);
        chk("lat_busy_N", busy, 1);
        tick(); tick(); tick();
        chk("lat_coll_N3", collision, 0);
        chk("lat_busy_N3", busy, 0);
        model_apply(5, 3, 1);
        chk_px("lat_px_N4", 5, 3);

        drive(5, 3, 2);
        tick(); tick();
        chk("hit_coll_N2", collision, 0);
        tick();
        chk("hit_coll_N3", collision, 1);
        model_apply(5, 3, 2);
        chk_px("hit_px", 5, 3);
        pulse_clear();
        chk("hit_cleared", collision, 0);

        // Clear arriving on the same edge as a set loses to the set.
        drive(5, 3, 3);
        tick(); tick();
        coll_clear = 1'b1;
        tick();
        coll_clear = 1'b0;
        chk("set_beats_clear", collision, 1);
        model_apply(5, 3, 3);
        pulse_clear();
        chk("set_clear_after", collision, 0);

        drive(7, 7, 1);
        drive(7, 7, 4);
        model_apply(7, 7, 1);
        model_apply(7, 7, 4);
        wait_idle(20);
        chk("fwd_coll", collision, ref_coll);
        chk_px("fwd_px", 7, 7);
        pulse_clear();

        drive(W, 0, 1);
        chk("oor_x_busy", busy, 0);
        drive(0, H, 1);
        chk("oor_y_busy", busy, 0);
        tick();
        chk("oor_overflow", overflow, 0);
        chk_px("oor_px01", 0, 1);
        chk_px("oor_px00", 0, 0);

        drive(9, 9, 1);
        drive(9, 9, 0);
        model_apply(9, 9, 1);
        model_apply(9, 9, 0);
        wait_idle(20);
        chk("erase_coll", collision, 0);
        chk_px("erase_px", 9, 9);

        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(10 + i, 0, 1);
            if (i < D) model_apply(10 + i, 0, 1);
            if (i == 2) chk("frz_full_3", pif.full, 0);
            if (i == 3) chk("frz_full_4", pif.full, 1);
        end
        chk("frz_overflow", overflow, 1);
        chk("frz_full_5", pif.full, 1);
        freeze = 1'b0;
        tick();
        chk("drain_full", pif.full, 0);
        tick(); tick(); tick();
        chk("drain_overflow_held", overflow, 1);
        wait_idle(20);
        for (int i = 0; i < 5; i++) chk_px("drain_px", 10 + i, 0);
        chk("drain_coll", collision, 0);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);

        drive(W-1, H-1, 5);
        model_apply(W-1, H-1, 5);
        wait_idle(20);
        chk_px("corner_px", W-1, H-1);
        pulse_clear();

        for (int round = 0; round < 6; round++) begin
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = int'($urandom_range(0, 15));
                    x = int'($urandom_range(0, 15));
                    y = int'($urandom_range(0, 15));
                    if (r == 0) x = int'($urandom_range(W, 255));
                    if (r == 1) y = int'($urandom_range(H, 127));
                    c = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
                    drive(x, y, c);
                    model_apply(x, y, c);
                end else begin
                    tick();
                end
            end
            wait_idle(20);
            chk("rnd_coll", collision, ref_coll);
            chk("rnd_overflow", overflow, 0);
            pulse_clear();
            for (int k = 0; k < 8; k++)
                chk_px("rnd_px", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // Reset while writes are queued: they must never reach the RAM.
        freeze = 1'b1;
        drive(1, 1, (ref_mem[1*W + 1] == 0) ? 6 : 0);
        drive(2, 2, (ref_mem[2*W + 2] == 0) ? 6 : 0);
        chk("mid_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", pif.full, 0);
        tick();
        freeze = 1'b0;
        resetn = 1'b1;
        tick(); tick();
`ifdef PIXEL_SINK_CLEAR_ON_RESET_EN
        foreach (ref_mem[i]) ref_mem[i] = 0;
        wait_idle(20000);
`else
        wait_idle(20);
`endif
        ref_coll = 1'b0;
        chk("mid_coll", collision, 0);
        chk_px("mid_px11", 1, 1);
        chk_px("mid_px22", 2, 2);
        chk_px("mid_px77", 7, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
